// File: rtl/alisim_pkg.sv
// Shared definitions for the phylogenetic simulation datapath: base encoding,
// random-sample width and the site sampler's control states.
package alisim_pkg;

    localparam int RAND_W = 11;

    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    localparam int NUM_BASES = 4;
    localparam int NUM_COLS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sampler_state_t;

    // Uniform cumulative table: column c holds (c+1)/4 of the sample range.
    function automatic int default_threshold(input int col, input int width);
        return (col + 1) << (width - 2);
    endfunction

endpackage

// File: rtl/site_sampler_cdf_select.sv
// Three-threshold priority encoder: returns the index of the first cumulative
// threshold that the uniform sample falls below, or 3 if none.
module cdf_select #(
    parameter int W = 11
) (
    input  logic [W-1:0] u,
    input  logic [W-1:0] thr0,
    input  logic [W-1:0] thr1,
    input  logic [W-1:0] thr2,
    output logic [1:0]   base
);

    // First match wins, so non-monotone tables still produce a defined result.
    always_comb begin
        base = 2'd3;
        if (u < thr0) begin
            base = 2'd0;
        end else if (u < thr1) begin
            base = 2'd1;
        end else if (u < thr2) begin
            base = 2'd2;
        end
    end

endmodule

// File: rtl/site_sampler.sv
// Per-site child nucleotide sampler: maps each parent base through a
// programmable cumulative substitution table using the LFSR's random word.
module site_sampler #(
    parameter int RAND_W = 11,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [32:0]       rnd,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [RAND_W-1:0] cfg_data,
    input  logic              start,
    input  logic [LEN_W-1:0]  seq_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_base,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_base,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    import alisim_pkg::*;

    sampler_state_t    state_reg;
    sampler_state_t    state_next;
    logic [LEN_W-1:0]  count_reg;
    logic [LEN_W-1:0]  len_reg;
    logic              last_acc_reg;
    logic              out_valid_reg;
    logic [1:0]        out_base_reg;
    logic              out_last_reg;

    logic [NUM_COLS*RAND_W-1:0] row_thr [NUM_BASES];
    logic [NUM_COLS*RAND_W-1:0] sel_row;
    logic                       cfg_wr_en;
    logic                       accept;
    logic                       out_hs;
    logic                       site_is_last;
    logic [1:0]                 sampled_base;
    logic [RAND_W-1:0]          u;
    logic                       rnd_unused;

    assign u          = rnd[RAND_W-1:0];
    assign rnd_unused = ^rnd[32:RAND_W];

    // Column 3 of the address space is not backed by a register.
    assign cfg_wr_en = cfg_we && (state_reg == ST_IDLE) && (cfg_addr[1:0] != 2'd3);

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_BASES; gi++) begin : gen_row
            logic [RAND_W-1:0] thr_reg [NUM_COLS];
            for (gj = 0; gj < NUM_COLS; gj++) begin : gen_col
                localparam logic [RAND_W-1:0] DEF_THR =
                    RAND_W'(default_threshold(gj, RAND_W));
                localparam logic [3:0] ADDR = 4'(gi * 4 + gj);
                always_ff @(posedge clk) begin
                    if (reset) begin
                        thr_reg[gj] <= DEF_THR;
                    end else if (cfg_wr_en && (cfg_addr == ADDR)) begin
                        thr_reg[gj] <= cfg_data;
                    end
                end
            end
            assign row_thr[gi] = {thr_reg[2], thr_reg[1], thr_reg[0]};
        end
    endgenerate

    assign sel_row = row_thr[in_base];

    cdf_select #(
        .W (RAND_W)
    ) u_cdf_select (
        .u    (u),
        .thr0 (sel_row[RAND_W-1:0]),
        .thr1 (sel_row[2*RAND_W-1:RAND_W]),
        .thr2 (sel_row[3*RAND_W-1:2*RAND_W]),
        .base (sampled_base)
    );

    assign in_ready     = (state_reg == ST_RUN) && (!out_valid_reg || out_ready) && !last_acc_reg;
    assign accept       = in_valid && in_ready;
    assign out_hs       = out_valid_reg && out_ready;
    assign site_is_last = (count_reg == (len_reg - LEN_W'(1)));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (seq_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (out_hs && out_last_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            len_reg       <= '0;
            last_acc_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_base_reg  <= 2'd0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && start) begin
                len_reg      <= seq_len;
                count_reg    <= '0;
                last_acc_reg <= 1'b0;
            end
            // An accept in the same cycle as an output handshake simply reloads.
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_base_reg  <= sampled_base;
                out_last_reg  <= site_is_last;
                count_reg     <= count_reg + LEN_W'(1);
                if (site_is_last) begin
                    last_acc_reg <= 1'b1;
                end
            end else if (out_hs) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_base  = out_base_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg == ST_RUN);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_site_sampler.sv
// Directed bench for site_sampler: table-driven sampling runs plus hand-written
// stall, zero-length, ignore-in-run and mid-run reset sequences.
module tb_site_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic [32:0] rnd;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [10:0] cfg_data;
    logic        start;
    logic [15:0] seq_len;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_base;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_base;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    site_sampler #(
        .RAND_W (11),
        .LEN_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rnd       (rnd),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .seq_len   (seq_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_base  (out_base),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  parent;
        logic [10:0] u;
        logic [1:0]  exp_base;
    } vec_t;

    vec_t vecs [13];
    int   run_len [4] = '{4, 2, 1, 6};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [10:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] n);
        start   = 1'b1;
        seq_len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic feed_site(input logic [1:0] p, input logic [10:0] u,
                             input logic [1:0] exp_b, input logic exp_last);
        in_valid  = 1'b1;
        in_base   = p;
        rnd       = {22'($urandom), u};
        out_ready = 1'b1;
        #1;
        check("in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_base", 32'(out_base), 32'(exp_b));
        check("out_last", 32'(out_last), 32'(exp_last));
    endtask

    task automatic finish_run();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        check("in_ready_after_last", 32'(in_ready), 32'd0);
        tick();
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("out_valid_in_done", 32'(out_valid), 32'd0);
        tick();
        check("done_cleared", 32'(done), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_out_base"}, 32'(out_base), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int idx;

        vecs[0]  = '{2'd0, 11'd100,  2'd0};
        vecs[1]  = '{2'd0, 11'd600,  2'd1};
        vecs[2]  = '{2'd0, 11'd1100, 2'd2};
        vecs[3]  = '{2'd0, 11'd2000, 2'd3};
        vecs[4]  = '{2'd2, 11'd5,    2'd2};
        vecs[5]  = '{2'd2, 11'd2047, 2'd3};
        vecs[6]  = '{2'd0, 11'd5,    2'd0};
        vecs[7]  = '{2'd2, 11'd0,    2'd2};
        vecs[8]  = '{2'd0, 11'd511,  2'd0};
        vecs[9]  = '{2'd0, 11'd1535, 2'd2};
        vecs[10] = '{2'd0, 11'd1536, 2'd3};
        vecs[11] = '{2'd1, 11'd1024, 2'd2};
        vecs[12] = '{2'd3, 11'd1023, 2'd1};

        reset     = 1'b1;
        rnd       = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        start     = 1'b0;
        seq_len   = '0;
        in_valid  = 1'b0;
        in_base   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check_quiet("reset");
        reset = 1'b0;
        tick();

        // Table-driven runs; T[2] = {0, 0, 2047} is programmed before run 1.
        idx = 0;
        for (int r = 0; r < 4; r++) begin
            if (r == 1) begin
                cfg_write(4'd8, 11'd0);
                cfg_write(4'd9, 11'd0);
                cfg_write(4'd10, 11'd2047);
            end
            start_run(16'(run_len[r]));
            check("busy_run", 32'(busy), 32'd1);
            for (int s = 0; s < run_len[r]; s++) begin
                feed_site(vecs[idx].parent, vecs[idx].u, vecs[idx].exp_base,
                          (s == run_len[r] - 1));
                idx++;
            end
            finish_run();
        end

        // Write issued together with start lands before the first sample: T[1][0] = 0.
        cfg_we   = 1'b1;
        cfg_addr = 4'd4;
        cfg_data = 11'd0;
        start_run(16'd1);
        cfg_we = 1'b0;
        feed_site(2'd1, 11'd100, 2'd1, 1'b1);
        finish_run();

        // Output stall: three cycles of out_ready low with changing rnd.
        start_run(16'd3);
        feed_site(2'd0, 11'd100, 2'd0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_base   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            rnd = {22'($urandom), 11'(k * 700 + 1)};
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_base", 32'(out_base), 32'd0);
            check("stall_out_last", 32'(out_last), 32'd0);
        end
        feed_site(2'd0, 11'd600, 2'd1, 1'b0);
        feed_site(2'd0, 11'd2000, 2'd3, 1'b1);
        finish_run();

        // Zero-length run goes straight to DONE.
        start_run(16'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_out_valid", 32'(out_valid), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        tick();
        check("zero_done_cleared", 32'(done), 32'd0);
        check("zero_out_valid2", 32'(out_valid), 32'd0);

        // cfg_we and start during RUN must be ignored.
        start_run(16'd2);
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 11'd0;
        start    = 1'b1;
        seq_len  = 16'd7;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        check("busy_after_poke", 32'(busy), 32'd1);
        feed_site(2'd0, 11'd100, 2'd0, 1'b0);
        feed_site(2'd0, 11'd1100, 2'd2, 1'b1);
        finish_run();
        start_run(16'd1);
        feed_site(2'd0, 11'd100, 2'd0, 1'b1);
        finish_run();

        // Mid-run reset after two of five sites, then a full run on defaults.
        start_run(16'd5);
        feed_site(2'd2, 11'd100, 2'd2, 1'b0);
        feed_site(2'd2, 11'd600, 2'd2, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        check_quiet("midreset");
        reset = 1'b0;
        tick();
        check("post_reset_done", 32'(done), 32'd0);
        check("post_reset_out_valid", 32'(out_valid), 32'd0);
        start_run(16'd5);
        feed_site(2'd2, 11'd100, 2'd0, 1'b0);
        feed_site(2'd2, 11'd600, 2'd1, 1'b0);
        feed_site(2'd2, 11'd1100, 2'd2, 1'b0);
        feed_site(2'd2, 11'd2000, 2'd3, 1'b0);
        feed_site(2'd2, 11'd512, 2'd1, 1'b1);
        finish_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
